mem_port_arbiter: RTL and testbench

- Shares the single synchronous memory port between two requesters:
  - requester 0: core instruction fetch.
  - requester 1: core data load/store or the host program loader.
- Latches one request and drives the memory-side address, data, length and load/store strobes for exactly one cycle.
- Waits a fixed read latency, then returns the load data, or a store acknowledge, with a one-cycle done pulse.
- Sits between the core's memory interface signals and the memory model or SRAM.

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-side and status signals around the shared memory port.
// slave = the arbiter itself; master = the environment (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  r0_req;
    logic [DATA_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic [1:0]            r0_len;
    logic                  r0_store;
    logic                  r0_unsigned;
    logic                  r0_gnt;
    logic                  r0_done;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_req;
    logic [DATA_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic [1:0]            r1_len;
    logic                  r1_store;
    logic                  r1_unsigned;
    logic                  r1_gnt;
    logic                  r1_done;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_len;
    logic                  mem_unsigned;
    logic                  mem_load;
    logic                  mem_store;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic                  last_grant;

    modport slave (
        input  r0_req, r0_addr, r0_wdata, r0_len, r0_store, r0_unsigned,
        input  r1_req, r1_addr, r1_wdata, r1_len, r1_store, r1_unsigned,
        input  mem_rdata,
        output r0_gnt, r0_done, r0_rdata,
        output r1_gnt, r1_done, r1_rdata,
        output mem_addr, mem_wdata, mem_len, mem_unsigned, mem_load, mem_store,
        output busy, last_grant
    );

    modport master (
        output r0_req, r0_addr, r0_wdata, r0_len, r0_store, r0_unsigned,
        output r1_req, r1_addr, r1_wdata, r1_len, r1_store, r1_unsigned,
        output mem_rdata,
        input  r0_gnt, r0_done, r0_rdata,
        input  r1_gnt, r1_done, r1_rdata,
        input  mem_addr, mem_wdata, mem_len, mem_unsigned, mem_load, mem_store,
        input  busy, last_grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous memory port: one access in flight,
// one-cycle memory strobe, fixed read latency, one-cycle done pulse back to the winner.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | sample requests, pick and latch a winner
// S_ACCESS | drive latched access onto the port; grant pulse to the winner
// S_WAIT   | count down the read latency; capture mem_rdata on the last cycle
// S_DONE   | done pulse (and load data) to the winner
module mem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

    logic [1:0]            state_q,  state_d;
    logic                  win_q,    win_d;
    logic                  last_q,   last_d;
    logic [DATA_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [1:0]            len_q,    len_d;
    logic                  uns_q,    uns_d;
    logic                  store_q,  store_d;
    logic [2:0]            cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic pick;
    logic in_access;
    logic in_done;
    logic load_done;

    // Contention goes to requester 0 in fixed mode, otherwise to the one not served last.
    always_comb begin
        pick = bus.r1_req;
        if (bus.r0_req && bus.r1_req) begin
            pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        len_d    = len_q;
        uns_d    = uns_q;
        store_d  = store_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.r0_req || bus.r1_req) begin
                    win_d   = pick;
                    last_d  = pick;
                    addr_d  = pick ? bus.r1_addr     : bus.r0_addr;
                    wdata_d = pick ? bus.r1_wdata    : bus.r0_wdata;
                    len_d   = pick ? bus.r1_len      : bus.r0_len;
                    uns_d   = pick ? bus.r1_unsigned : bus.r0_unsigned;
                    store_d = pick ? bus.r1_store    : bus.r0_store;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (store_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    result_d = bus.mem_rdata;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            len_q    <= 2'd0;
            uns_q    <= 1'b0;
            store_q  <= 1'b0;
            cnt_q    <= 3'd0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            len_q    <= len_d;
            uns_q    <= uns_d;
            store_q  <= store_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign in_access = (state_q == S_ACCESS);
    assign in_done   = (state_q == S_DONE);
    assign load_done = in_done && !store_q;

    assign bus.r0_gnt   = in_access && !win_q;
    assign bus.r1_gnt   = in_access &&  win_q;
    assign bus.r0_done  = in_done && !win_q;
    assign bus.r1_done  = in_done &&  win_q;
    assign bus.r0_rdata = (load_done && !win_q) ? result_q : '0;
    assign bus.r1_rdata = (load_done &&  win_q) ? result_q : '0;

    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_len      = len_q;
    assign bus.mem_unsigned = uns_q;
    assign bus.mem_load     = in_access && !store_q;
    assign bus.mem_store    = in_access &&  store_q;

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.last_grant = last_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 1/2/3, last one fixed priority),
// each compared every cycle against a transaction-offset model, plus directed literal checks.
module tb_mem_port_arbiter;
    logic clk;

    logic        r_req   [3][2];
    logic [31:0] r_addr  [3][2];
    logic [31:0] r_wdata [3][2];
    logic [1:0]  r_len   [3][2];
    logic        r_store [3][2];
    logic        r_uns   [3][2];
    logic [31:0] mrdata  [3];
    logic        rst_a   [3];

    logic [1:0]  o_gnt [3];
    logic [1:0]  o_done [3];
    logic [31:0] o_rd0 [3];
    logic [31:0] o_rd1 [3];
    logic [31:0] o_addr [3];
    logic [31:0] o_wdata [3];
    logic [1:0]  o_len [3];
    logic        o_uns [3];
    logic        o_load [3];
    logic        o_store [3];
    logic        o_busy [3];
    logic        o_last [3];

    int errors = 0;
    int checks = 0;
    int nprint = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int RL = (g == 0) ? 1 : ((g == 1) ? 2 : 3);
        localparam bit FP = (g == 2);

        logic rst_l;
        assign rst_l = rst_a[g];

        mem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

        mem_port_arbiter #(
            .DATA_WIDTH(32), .READ_LATENCY(RL), .FIXED_PRIORITY(FP ? 1 : 0)
        ) dut (
            .clk(clk), .reset(rst_l), .bus(bus)
        );

        assign bus.r0_req      = r_req[g][0];
        assign bus.r0_addr     = r_addr[g][0];
        assign bus.r0_wdata    = r_wdata[g][0];
        assign bus.r0_len      = r_len[g][0];
        assign bus.r0_store    = r_store[g][0];
        assign bus.r0_unsigned = r_uns[g][0];
        assign bus.r1_req      = r_req[g][1];
        assign bus.r1_addr     = r_addr[g][1];
        assign bus.r1_wdata    = r_wdata[g][1];
        assign bus.r1_len      = r_len[g][1];
        assign bus.r1_store    = r_store[g][1];
        assign bus.r1_unsigned = r_uns[g][1];
        assign bus.mem_rdata   = mrdata[g];

        assign o_gnt[g]   = {bus.r1_gnt, bus.r0_gnt};
        assign o_done[g]  = {bus.r1_done, bus.r0_done};
        assign o_rd0[g]   = bus.r0_rdata;
        assign o_rd1[g]   = bus.r1_rdata;
        assign o_addr[g]  = bus.mem_addr;
        assign o_wdata[g] = bus.mem_wdata;
        assign o_len[g]   = bus.mem_len;
        assign o_uns[g]   = bus.mem_unsigned;
        assign o_load[g]  = bus.mem_load;
        assign o_store[g] = bus.mem_store;
        assign o_busy[g]  = bus.busy;
        assign o_last[g]  = bus.last_grant;

        // Model: t is the offset of the current cycle from the sampling IDLE cycle N
        // (t = -1 when idle); duration is 2 for stores, 2+RL for loads.
        int          t   = -1;
        logic        w   = 1'b0;
        logic        st  = 1'b0;
        logic        lst = 1'b1;
        logic [31:0] ma  = '0;
        logic [31:0] mw  = '0;
        logic [31:0] res = '0;
        logic [1:0]  ml  = '0;
        logic        mu  = 1'b0;

        initial forever begin
            @(posedge clk or negedge rst_l);
            if (!rst_l) begin
                t = -1; w = 1'b0; st = 1'b0; lst = 1'b1;
                ma = '0; mw = '0; res = '0; ml = '0; mu = 1'b0;
            end else if (t < 0) begin
                if (r_req[g][0] || r_req[g][1]) begin
                    if (r_req[g][0] && r_req[g][1]) w = FP ? 1'b0 : ~lst;
                    else                            w = r_req[g][1];
                    ma  = r_addr[g][w];
                    mw  = r_wdata[g][w];
                    ml  = r_len[g][w];
                    mu  = r_uns[g][w];
                    st  = r_store[g][w];
                    lst = w;
                    t   = 1;
                end
            end else begin
                if (!st && t == 1 + RL) res = mrdata[g];
                if (t == (st ? 2 : 2 + RL)) t = -1;
                else                        t = t + 1;
            end
        end

        logic [138:0] act_v, exp_v;
        logic [1:0]   wmask;
        int           dur;

        initial forever begin
            @(negedge clk);
            dur   = st ? 2 : 2 + RL;
            wmask = w ? 2'b10 : 2'b01;
            act_v = {o_gnt[g], o_done[g], o_rd0[g], o_rd1[g], o_addr[g], o_wdata[g],
                     o_len[g], o_uns[g], o_load[g], o_store[g], o_busy[g], o_last[g]};
            exp_v = {(t == 1) ? wmask : 2'b00,
                     (t == dur) ? wmask : 2'b00,
                     (t == dur && !st && !w) ? res : 32'h0,
                     (t == dur && !st &&  w) ? res : 32'h0,
                     ma, mw, ml, mu,
                     (t == 1 && !st), (t == 1 && st), (t >= 1), lst};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL model_cmp inst%0d t=%0t got=%h expected=%h", g, $time, act_v, exp_v);
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 30 && o_busy[g]; i++) tick();
        check("idle_reached", {31'd0, o_busy[g]}, 32'd0);
    endtask

    int   n, prev, viol, r0cnt, r1cnt, r0late;
    logic cur, got, bad, d;
    logic order [4];
    int   gap   [4];

    initial begin
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 2; k++) begin
                r_req[g][k] = 1'b0; r_addr[g][k] = '0; r_wdata[g][k] = '0;
                r_len[g][k] = '0; r_store[g][k] = 1'b0; r_uns[g][k] = 1'b0;
            end
            mrdata[g] = '0;
            rst_a[g]  = 1'b0;
        end
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            check("rst_last", {31'd0, o_last[g]}, 32'd1);
            check("rst_busy", {31'd0, o_busy[g]}, 32'd0);
            check("rst_gnt_done", {28'd0, o_gnt[g], o_done[g]}, 32'd0);
            check("rst_addr", o_addr[g], 32'd0);
        end
        for (int g = 0; g < 3; g++) rst_a[g] = 1'b1;
        repeat (2) tick();

        // Load from r0, latency 1
        r_addr[0][0] = 32'h100; r_len[0][0] = 2'd3; r_store[0][0] = 1'b0; r_req[0][0] = 1'b1;
        tick();
        check("ld_gnt", {30'd0, o_gnt[0]}, 32'b01);
        check("ld_load", {31'd0, o_load[0]}, 32'd1);
        check("ld_addr", o_addr[0], 32'h100);
        check("ld_len", {30'd0, o_len[0]}, 32'd3);
        r_req[0][0] = 1'b0; r_addr[0][0] = 32'hFFFF_0000;
        tick();
        mrdata[0] = 32'hDEADBEEF;
        check("ld_wait_addr", o_addr[0], 32'h100);
        check("ld_wait_load", {31'd0, o_load[0]}, 32'd0);
        tick();
        check("ld_done", {30'd0, o_done[0]}, 32'b01);
        check("ld_rdata", o_rd0[0], 32'hDEADBEEF);
        mrdata[0] = '0;
        tick();
        check("ld_after_rdata", o_rd0[0], 32'd0);
        check("ld_after_busy", {31'd0, o_busy[0]}, 32'd0);

        // Store from r1
        r_addr[0][1] = 32'h40; r_wdata[0][1] = 32'h12345678; r_len[0][1] = 2'd1;
        r_store[0][1] = 1'b1; r_req[0][1] = 1'b1;
        tick();
        check("st_gnt", {30'd0, o_gnt[0]}, 32'b10);
        check("st_store", {31'd0, o_store[0]}, 32'd1);
        check("st_load", {31'd0, o_load[0]}, 32'd0);
        check("st_wdata", o_wdata[0], 32'h12345678);
        check("st_len", {30'd0, o_len[0]}, 32'd1);
        check("st_addr", o_addr[0], 32'h40);
        r_req[0][1] = 1'b0;
        tick();
        check("st_done", {30'd0, o_done[0]}, 32'b10);
        check("st_rdata", o_rd1[0], 32'd0);
        check("st_strobe_off", {31'd0, o_store[0]}, 32'd0);
        tick();

        // Short r1 pulse during r0's transaction is never sampled
        r_addr[0][0] = 32'h200; r_store[0][0] = 1'b0; r_req[0][0] = 1'b1;
        tick();
        r_req[0][0] = 1'b0;
        tick();
        r_req[0][1] = 1'b1; r_addr[0][1] = 32'h300; r_store[0][1] = 1'b1;
        tick();
        check("pulse_r0_done", {30'd0, o_done[0]}, 32'b01);
        r_req[0][1] = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            tick();
            bad = bad | o_gnt[0][1] | o_store[0] | o_load[0];
        end
        check("pulse_no_txn", {31'd0, bad}, 32'd0);
        check("pulse_addr_hold", o_addr[0], 32'h200);

        // Round-robin with both held, latency 2
        r_addr[1][0] = 32'h10; r_addr[1][1] = 32'h20;
        r_store[1][0] = 1'b0; r_store[1][1] = 1'b0;
        r_req[1][0] = 1'b1; r_req[1][1] = 1'b1;
        n = 0; prev = 0; viol = 0; cur = 1'b0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            tick();
            if (o_gnt[1] != 2'b00) begin
                if (o_gnt[1] == 2'b11) viol++;
                order[n] = o_gnt[1][1];
                gap[n]   = c - prev;
                prev     = c;
                cur      = o_gnt[1][1];
                n++;
            end
            if (o_done[1] != 2'b00 && o_done[1] != (cur ? 2'b10 : 2'b01)) viol++;
        end
        check("rr_grants", n, 32'd4);
        check("rr_order", {28'd0, order[0], order[1], order[2], order[3]}, 32'b0101);
        for (int i = 1; i < 4; i++) check("rr_spacing", gap[i], 32'd5);
        check("rr_loser_quiet", viol, 32'd0);
        r_req[1][0] = 1'b0; r_req[1][1] = 1'b0;
        wait_idle(1);

        // Fixed priority, latency 3
        r_store[2][0] = 1'b0; r_store[2][1] = 1'b1;
        r_req[2][0] = 1'b1; r_req[2][1] = 1'b1;
        r0cnt = 0; r1cnt = 0;
        repeat (24) begin
            tick();
            if (o_gnt[2][0]) r0cnt++;
            if (o_gnt[2][1]) r1cnt++;
        end
        check("fp_r1_starved", r1cnt, 32'd0);
        check("fp_r0_served", {31'd0, r0cnt >= 3}, 32'd1);
        r_req[2][0] = 1'b0;
        got = 1'b0; r0late = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            if (o_gnt[2][0]) r0late++;
            if (o_gnt[2][1]) got = 1'b1;
        end
        check("fp_r1_after_drop", {31'd0, got}, 32'd1);
        check("fp_no_r0_after_drop", r0late, 32'd0);
        r_req[2][1] = 1'b0;
        wait_idle(2);

        // Reset in WAIT, latency 2
        r_addr[1][0] = 32'h80; r_store[1][0] = 1'b0; r_req[1][0] = 1'b1;
        tick();
        r_req[1][0] = 1'b0;
        tick();
        @(posedge clk);
        #2 rst_a[1] = 1'b0;
        #1;
        check("rstw_busy", {31'd0, o_busy[1]}, 32'd0);
        check("rstw_load", {31'd0, o_load[1]}, 32'd0);
        check("rstw_gnt_done", {28'd0, o_gnt[1], o_done[1]}, 32'd0);
        check("rstw_last", {31'd0, o_last[1]}, 32'd1);
        @(negedge clk);
        rst_a[1] = 1'b1;
        d = 1'b0;
        repeat (8) begin
            tick();
            d = d | o_done[1][0] | o_done[1][1];
        end
        check("rstw_no_done", {31'd0, d}, 32'd0);
        r_addr[1][1] = 32'h90; r_store[1][1] = 1'b1; r_req[1][1] = 1'b1;
        tick();
        check("rstw_regrant", {30'd0, o_gnt[1]}, 32'b10);
        check("rstw_regrant_addr", o_addr[1], 32'h90);
        r_req[1][1] = 1'b0;
        wait_idle(1);

        // Random traffic; inputs change every cycle, including mid-transaction
        repeat (3000) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                for (int k = 0; k < 2; k++) begin
                    r_req[g][k]   = ($urandom_range(3, 0) != 0);
                    r_addr[g][k]  = $urandom;
                    r_wdata[g][k] = $urandom;
                    r_len[g][k]   = 2'($urandom_range(3, 0));
                    r_store[g][k] = 1'($urandom_range(1, 0));
                    r_uns[g][k]   = 1'($urandom_range(1, 0));
                end
                mrdata[g] = $urandom;
            end
        end
        for (int g = 0; g < 3; g++) begin
            r_req[g][0] = 1'b0; r_req[g][1] = 1'b0;
        end
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
